// File: rtl/wishbone_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_sram_bridge
// Brief    : Wishbone classic slave bridging one RW+R dual-port OpenRAM macro;
//            registered FSM, out-of-window accesses answered with err.
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_sram_bridge #(
    parameter int          NO_OF_ROWS   = 256,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [31:0] BASE_MASK    = 32'hFFFF_0000,
    parameter int          READ_LATENCY = 1,
    parameter int          SPLIT_ROW    = NO_OF_ROWS / 2
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [DATA_WIDTH/8-1:0]       wbs_sel_i,
    input  logic [DATA_WIDTH-1:0]         wbs_dat_i,
    input  logic [31:0]                   wbs_adr_i,
    output logic                          wbs_ack_o,
    output logic                          wbs_err_o,
    output logic [DATA_WIDTH-1:0]         wbs_dat_o,
    output logic                          ram_clk0,
    output logic                          ram_csb0,
    output logic                          ram_web0,
    output logic [DATA_WIDTH/8-1:0]       ram_wmask0,
    output logic [$clog2(NO_OF_ROWS)-1:0] ram_addr0,
    output logic [DATA_WIDTH-1:0]         ram_dout0,
    input  logic [DATA_WIDTH-1:0]         ram_din0,
    output logic                          ram_clk1,
    output logic                          ram_csb1,
    output logic [$clog2(NO_OF_ROWS)-1:0] ram_addr1,
    input  logic [DATA_WIDTH-1:0]         ram_din1
);

    localparam int c_AW = $clog2(NO_OF_ROWS);
    localparam int c_NB = DATA_WIDTH / 8;
    localparam int c_BO = $clog2(c_NB);

    localparam logic [31:0]   c_WIN_BYTES = 32'(NO_OF_ROWS * c_NB);
    localparam logic [c_AW:0] c_SPLIT     = (c_AW + 1)'(SPLIT_ROW);
    localparam logic [1:0]    c_LAT_INIT  = 2'(READ_LATENCY - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_ISSUE = 3'd1;
    localparam logic [2:0] c_S_WAIT  = 3'd2;
    localparam logic [2:0] c_S_ACK   = 3'd3;
    localparam logic [2:0] c_S_ERR   = 3'd4;

    logic            w_req;
    logic [31:0]     w_offset;
    logic            w_hit;
    logic [c_AW-1:0] w_row;
    logic            w_hi_port;

    logic [2:0]            r_state;
    logic [1:0]            r_lat_cnt;
    logic                  r_is_write;
    logic                  r_port1;
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_csb0;
    logic                  r_csb1;
    logic                  r_web0;
    logic [c_NB-1:0]       r_wmask0;
    logic [c_AW-1:0]       r_row;
    logic [DATA_WIDTH-1:0] r_dout0;

    // A wrapped (negative) offset compares huge, so it misses as well.
    assign w_req     = wbs_cyc_i & wbs_stb_i;
    assign w_offset  = wbs_adr_i - BASE_ADDR;
    assign w_hit     = ((wbs_adr_i & BASE_MASK) == BASE_ADDR) && (w_offset < c_WIN_BYTES);
    assign w_row     = w_offset[c_AW+c_BO-1:c_BO];
    assign w_hi_port = ({1'b0, w_row} >= c_SPLIT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= c_S_IDLE;
            r_lat_cnt  <= '0;
            r_is_write <= 1'b0;
            r_port1    <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat      <= '0;
            r_csb0     <= 1'b1;
            r_csb1     <= 1'b1;
            r_web0     <= 1'b1;
            r_wmask0   <= '0;
            r_row      <= '0;
            r_dout0    <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            r_state    <= c_S_ISSUE;
                            r_row      <= w_row;
                            r_is_write <= wbs_we_i;
                            r_port1    <= ~wbs_we_i & w_hi_port;
                            if (wbs_we_i) begin
                                r_dout0  <= wbs_dat_i;
                                r_wmask0 <= wbs_sel_i;
                                r_web0   <= 1'b0;
                                r_csb0   <= 1'b0;
                            end else if (w_hi_port) begin
                                r_csb1 <= 1'b0;
                            end else begin
                                r_csb0 <= 1'b0;
                            end
                        end else begin
                            r_state <= c_S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                c_S_ISSUE: begin
                    // The macro captures at this edge, so the strobe ends regardless of abort.
                    r_csb0    <= 1'b1;
                    r_csb1    <= 1'b1;
                    r_web0    <= 1'b1;
                    r_lat_cnt <= c_LAT_INIT;
                    if (!wbs_cyc_i) begin
                        r_state <= c_S_IDLE;
                    end else if (r_is_write) begin
                        r_ack   <= 1'b1;
                        r_state <= c_S_ACK;
                    end else begin
                        r_state <= c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    if (!wbs_cyc_i) begin
                        r_state <= c_S_IDLE;
                    end else if (r_lat_cnt == 2'd0) begin
                        r_dat   <= r_port1 ? ram_din1 : ram_din0;
                        r_ack   <= 1'b1;
                        r_state <= c_S_ACK;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 2'd1;
                    end
                end
                c_S_ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                c_S_ERR: begin
                    r_err   <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_csb0  <= 1'b1;
                    r_csb1  <= 1'b1;
                    r_web0  <= 1'b1;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign ram_clk0   = wb_clk_i;
    assign ram_clk1   = wb_clk_i;
    assign wbs_ack_o  = r_ack;
    assign wbs_err_o  = r_err;
    assign wbs_dat_o  = r_dat;
    assign ram_csb0   = r_csb0;
    assign ram_csb1   = r_csb1;
    assign ram_web0   = r_web0;
    assign ram_wmask0 = r_wmask0;
    assign ram_addr0  = r_row;
    assign ram_addr1  = r_row;
    assign ram_dout0  = r_dout0;

endmodule
`default_nettype wire
